// File: rtl/coax_rx_frame_ctrl.sv
// Sequences the coax receiver around transmit activity and receive errors,
// and turns received word strobes into framed entries for the receive FIFO.
module coax_rx_frame_ctrl #(
   parameter int unsigned TX_HOLDOFF_CYCLES    = 16,
   parameter int unsigned RX_RESET_CYCLES      = 2,
   parameter int unsigned MAX_FRAME_WORDS      = 1024,
   parameter logic [9:0]  ERROR_FRAME_TOO_LONG = 10'b0000010000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_active,
   input  logic        rx_active,
   input  logic        rx_strobe,
   input  logic        rx_error,
   input  logic [9:0]  rx_data,
   output logic        rx_reset,
   input  logic        fifo_full,
   output logic        fifo_write,
   output logic [15:0] fifo_data,
   output logic        overflow,
   input  logic        overflow_clear,
   output logic [10:0] word_count
);

   localparam int unsigned HOLD_W = $clog2(TX_HOLDOFF_CYCLES + 1);
   localparam int unsigned CLR_W  = $clog2(RX_RESET_CYCLES + 1);
   localparam int unsigned CNT_W  = (HOLD_W > CLR_W) ? HOLD_W : CLR_W;
   localparam logic [10:0] WC_MAX = 11'h7FF;

   typedef enum logic [2:0] {
      IDLE,
      HOLDOFF,
      RECEIVE,
      ERROR_WRITE,
      RX_CLEAR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             sof;
   logic             rx_active_q;

   logic             tx_preempt_c;
   logic             frame_full_c;
   logic             wr_req_c;
   logic [15:0]      wr_data_c;

   assign tx_preempt_c = tx_active && (state != RX_CLEAR);
   assign frame_full_c = 32'(word_count) >= MAX_FRAME_WORDS;

   // FIFO entry requested this cycle; issued (or dropped on fifo_full) next edge
   always_comb begin
      wr_req_c  = 1'b0;
      wr_data_c = '0;
      if (!tx_preempt_c) begin
         case (state)
            IDLE: begin
               if (rx_error) begin
                  wr_req_c  = 1'b1;
                  wr_data_c = {1'b1, sof, 4'b0, rx_data};
               end
            end
            RECEIVE: begin
               if (rx_strobe) begin
                  wr_req_c  = 1'b1;
                  wr_data_c = frame_full_c ? {2'b10, 4'b0, ERROR_FRAME_TOO_LONG}
                                           : {1'b0, sof, 4'b0, rx_data};
               end else if (rx_error) begin
                  wr_req_c  = 1'b1;
                  wr_data_c = {1'b1, sof, 4'b0, rx_data};
               end
            end
            default: begin
               wr_req_c  = 1'b0;
               wr_data_c = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         sof         <= 1'b0;
         rx_active_q <= 1'b0;
         rx_reset    <= 1'b0;
         fifo_write  <= 1'b0;
         fifo_data   <= '0;
         overflow    <= 1'b0;
         word_count  <= '0;
      end else begin
         fifo_write  <= 1'b0;
         rx_active_q <= rx_active;
         if (overflow_clear) overflow <= 1'b0;

         // a dropped entry sets overflow after the clear so set wins
         if (wr_req_c) begin
            if (fifo_full) begin
               overflow <= 1'b1;
            end else begin
               fifo_write <= 1'b1;
               fifo_data  <= wr_data_c;
            end
         end

         if (tx_preempt_c) begin
            state    <= HOLDOFF;
            cnt      <= CNT_W'(TX_HOLDOFF_CYCLES);
            rx_reset <= 1'b1;
            sof      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (rx_error) begin
                     state <= ERROR_WRITE;
                  end else if (rx_active && !rx_active_q) begin
                     state      <= RECEIVE;
                     word_count <= '0;
                     sof        <= 1'b1;
                  end
               end
               HOLDOFF: begin
                  if (cnt == '0) begin
                     state    <= IDLE;
                     rx_reset <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               RECEIVE: begin
                  if (rx_strobe) begin
                     sof <= 1'b0;
                     if (frame_full_c) begin
                        state    <= RX_CLEAR;
                        rx_reset <= 1'b1;
                        cnt      <= CNT_W'(RX_RESET_CYCLES - 1);
                     end else begin
                        if (word_count != WC_MAX) word_count <= word_count + 11'd1;
                        // a pending error is taken on the next cycle
                        if (!rx_active && !rx_error) state <= IDLE;
                     end
                  end else if (rx_error) begin
                     state <= ERROR_WRITE;
                  end else if (!rx_active) begin
                     state <= IDLE;
                  end
               end
               ERROR_WRITE: begin
                  state    <= RX_CLEAR;
                  rx_reset <= 1'b1;
                  cnt      <= CNT_W'(RX_RESET_CYCLES - 1);
                  sof      <= 1'b0;
               end
               RX_CLEAR: begin
                  if (cnt == '0) begin
                     if (tx_active) begin
                        state <= HOLDOFF;
                        cnt   <= CNT_W'(TX_HOLDOFF_CYCLES);
                     end else begin
                        state    <= IDLE;
                        rx_reset <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_coax_rx_frame_ctrl.sv
// Directed bench for coax_rx_frame_ctrl: expected FIFO entries are queued with
// their due cycle when stimulus is driven and matched by a write monitor.
module tb_coax_rx_frame_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        tx_active, rx_active, rx_strobe, rx_error;
   logic [9:0]  rx_data;
   logic        rx_reset;
   logic        fifo_full;
   logic        fifo_write;
   logic [15:0] fifo_data;
   logic        overflow;
   logic        overflow_clear;
   logic [10:0] word_count;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   n;

   coax_rx_frame_ctrl #(
      .TX_HOLDOFF_CYCLES(16),
      .RX_RESET_CYCLES(2),
      .MAX_FRAME_WORDS(4),
      .ERROR_FRAME_TOO_LONG(10'b0000010000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .tx_active(tx_active),
      .rx_active(rx_active),
      .rx_strobe(rx_strobe),
      .rx_error(rx_error),
      .rx_data(rx_data),
      .rx_reset(rx_reset),
      .fifo_full(fifo_full),
      .fifo_write(fifo_write),
      .fifo_data(fifo_data),
      .overflow(overflow),
      .overflow_clear(overflow_clear),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // every FIFO write must match the oldest queued entry and its due cycle
   always @(negedge clk) begin
      if (fifo_write === 1'b1) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_write observed=%0h expected=none", fifo_data);
         end
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("entry_data", 32'(fifo_data), 32'(e.data));
            chk("entry_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [15:0] d);
      sb.push_back('{d, cyc + 1});
   endtask

   task automatic strobe(input logic [9:0] d, input logic [15:0] e, input bit expect_write);
      rx_strobe = 1'b1;
      rx_data   = d;
      if (expect_write) push(e);
      tick();
      rx_strobe = 1'b0;
   endtask

   // waits for rx_reset to rise, then counts the clocks it stays high
   task automatic measure_rst(output int cnt);
      int guard;
      cnt   = 0;
      guard = 0;
      while (rx_reset !== 1'b1 && guard < 20) begin tick(); guard++; end
      while (rx_reset === 1'b1 && guard < 100) begin cnt++; tick(); guard++; end
   endtask

   initial begin
      reset = 1'b1; tx_active = 1'b0; rx_active = 1'b0; rx_strobe = 1'b0;
      rx_error = 1'b0; rx_data = '0; fifo_full = 1'b0; overflow_clear = 1'b0;
      tick(); tick();
      chk("reset_rx_reset", 32'(rx_reset), 0);
      chk("reset_fifo_write", 32'(fifo_write), 0);
      chk("reset_fifo_data", 32'(fifo_data), 0);
      chk("reset_overflow", 32'(overflow), 0);
      chk("reset_word_count", 32'(word_count), 0);
      reset = 1'b0;
      tick();

      // three-word frame, back-to-back strobes
      rx_active = 1'b1; tick(); tick();
      strobe(10'h133, 16'h4133, 1'b1);
      strobe(10'h001, 16'h0001, 1'b1);
      strobe(10'h3FF, 16'h03FF, 1'b1);
      chk("frame3_word_count", 32'(word_count), 3);
      tick();
      rx_active = 1'b0; tick(); tick();
      chk("frame3_queue_drained", 32'(sb.size()), 0);

      // receive error after one word
      rx_active = 1'b1; tick();
      strobe(10'h055, 16'h4055, 1'b1);
      rx_error = 1'b1; rx_data = 10'h002; push(16'h8002);
      tick();
      rx_error = 1'b0; rx_active = 1'b0;
      measure_rst(n);
      chk("error_rx_reset_width", 32'(n), 2);
      chk("error_rx_reset_low", 32'(rx_reset), 0);
      chk("error_word_count", 32'(word_count), 1);
      tick();

      // strobe and error together: word first, then error entry
      rx_active = 1'b1; tick();
      rx_strobe = 1'b1; rx_error = 1'b1; rx_data = 10'h0AA; push(16'h40AA);
      tick();
      rx_strobe = 1'b0; rx_data = 10'h004; push(16'h8004);
      tick();
      rx_error = 1'b0; rx_active = 1'b0;
      measure_rst(n);
      chk("strobe_err_rx_reset_width", 32'(n), 2);
      tick();

      // transmit hold-off with a strobe arriving during it
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tx_active = 1'b1;
         rx_strobe = (i == 2);
         rx_data   = 10'h3C3;
         tick();
         if (rx_reset === 1'b1) n++;
      end
      tx_active = 1'b0; rx_strobe = 1'b0;
      tick();
      for (int g = 0; g < 100 && rx_reset === 1'b1; g++) begin n++; tick(); end
      chk("holdoff_rx_reset_width", 32'(n), 21);
      chk("holdoff_rx_reset_low", 32'(rx_reset), 0);
      tick();

      // FIFO full on the middle word, then overflow clear behaviour
      rx_active = 1'b1; tick();
      strobe(10'h101, 16'h4101, 1'b1);
      fifo_full = 1'b1;
      strobe(10'h102, 16'h0000, 1'b0);
      fifo_full = 1'b0;
      chk("ovf_set", 32'(overflow), 1);
      strobe(10'h103, 16'h0103, 1'b1);
      chk("ovf_word_count", 32'(word_count), 3);
      tick();
      chk("ovf_sticky", 32'(overflow), 1);
      overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
      chk("ovf_cleared", 32'(overflow), 0);
      fifo_full = 1'b1; overflow_clear = 1'b1;
      strobe(10'h104, 16'h0000, 1'b0);
      fifo_full = 1'b0; overflow_clear = 1'b0;
      chk("ovf_set_wins", 32'(overflow), 1);
      chk("ovf_word_count_dropped", 32'(word_count), 4);
      overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
      chk("ovf_cleared_again", 32'(overflow), 0);
      rx_active = 1'b0; tick(); tick();

      // over-length frame with a four-word limit
      rx_active = 1'b1; tick();
      strobe(10'h201, 16'h4201, 1'b1);
      strobe(10'h202, 16'h0202, 1'b1);
      strobe(10'h203, 16'h0203, 1'b1);
      strobe(10'h204, 16'h0204, 1'b1);
      strobe(10'h205, 16'h8010, 1'b1);
      rx_active = 1'b0;
      chk("toolong_word_count", 32'(word_count), 4);
      measure_rst(n);
      chk("toolong_rx_reset_width", 32'(n), 2);
      tick();

      // reset in the middle of a frame
      rx_active = 1'b1; tick();
      strobe(10'h011, 16'h4011, 1'b1);
      strobe(10'h012, 16'h0012, 1'b1);
      strobe(10'h013, 16'h0013, 1'b1);
      rx_strobe = 1'b1; rx_data = 10'h3AB;
      #1 reset = 1'b1;
      #1;
      chk("midreset_fifo_write", 32'(fifo_write), 0);
      chk("midreset_fifo_data", 32'(fifo_data), 0);
      chk("midreset_word_count", 32'(word_count), 0);
      chk("midreset_rx_reset", 32'(rx_reset), 0);
      chk("midreset_overflow", 32'(overflow), 0);
      tick();
      chk("midreset_held_write", 32'(fifo_write), 0);
      rx_strobe = 1'b0; rx_active = 1'b0;
      reset = 1'b0;
      tick(); tick();
      chk("midreset_after_write", 32'(fifo_write), 0);
      chk("final_queue_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
